cmp_iter: RTL and testbench
===========================

Name: cmp_iter

Overview:
- Parametrised, iterative magnitude comparator for FIFO-side compare logic in the slave FIFO path.
- Captures two WIDTH-bit operands with a valid/ready handshake and compares them MSB-first, CHUNK bits per cycle.
- Terminates early on the first unequal chunk and returns registered gt/eq/lt flags with a done pulse.
- Adds over the fixed 8-bit combinational compare: runtime signed/unsigned mode, multi-cycle operation for wide operands, early termination, and held results.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 8, bits compared per cycle. NCH = WIDTH/CHUNK chunks.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rstn_i  input  1  reset, synchronous, active-low.
- start_i  input  1  request valid; accepted when start_i && ready_o.
- a_i  input  WIDTH  operand A; sampled on accept.
- b_i  input  WIDTH  operand B; sampled on accept.
- signed_i  input  1  1 = two's-complement compare, 0 = unsigned; sampled on accept.
- ready_o  output  1  high when a new request can be accepted.
- busy_o  output  1  high while in RUN.
- done_o  output  1  one-cycle pulse; the result is valid in this cycle and held afterwards.
- gt_o  output  1  A > B.
- eq_o  output  1  A == B.
- lt_o  output  1  A < B.

Behaviour:
- Reset (rstn_i low at an edge): state = IDLE, ready_o = 1, busy_o = 0, done_o = 0, gt_o = eq_o = lt_o = 0, chunk index = 0.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE and RUN. ready_o = (state == IDLE); busy_o = (state == RUN).
- IDLE, on accept:
  - Register a_i, b_i and signed_i.
  - Set chunk index to NCH-1 (the MSB chunk).
  - Clear gt_o, eq_o and lt_o to 0.
  - Go to RUN.
  - start_i without ready_o is ignored; nothing is queued.
- RUN, each edge: compare chunk[idx] of A against chunk[idx] of B.
  - Signed mode: the top chunk is compared with the operand MSB inverted on both sides, so negative values order below positive. Lower chunks are always compared unsigned.
  - Chunks unequal: set gt_o or lt_o, pulse done_o, go to IDLE.
  - Chunks equal and idx == 0: set eq_o, pulse done_o, go to IDLE.
  - Chunks equal and idx > 0: decrement idx, stay in RUN.
- Latency: for an accept at edge k, done_o is high in the cycle after edge k+m.
  - m = 1 + number of leading equal chunks, so 1 ≤ m ≤ NCH.
  - NCH = 1 gives a fixed m of 1.
- Exactly one of gt_o/eq_o/lt_o is high from the done cycle until the next accept. All three are 0 from accept until done.
- The done cycle is in IDLE with ready_o = 1, so a start_i in that same cycle is accepted (back-to-back). This clears the flags at the next edge.
- Operand, mode and flag changes on the inputs during RUN have no effect, because the operands were captured on accept.

Test Plan (WIDTH=32, CHUNK=8):
- Reset: rstn_i = 0 for 2 edges -> ready_o = 1, busy_o = 0, done_o = 0, all flags 0.
- Equal operands: a = 0x12345678, b = 0x12345678, unsigned, accept at edge k -> busy_o high for 4 cycles, done_o at the cycle after edge k+4, eq_o = 1, gt_o = lt_o = 0, flags held until the next accept.
- Early termination and mode:
  - a = 0x80000000, b = 0x7FFFFFFF, unsigned -> done after 1 edge, gt_o = 1.
  - Same operands, signed -> done after 1 edge, lt_o = 1.
- Mid-width difference: a = 0x00010000, b = 0x0000FFFF -> done after 2 edges, gt_o = 1.
- Full-width difference: a = 0xFFFFFFFE, b = 0xFFFFFFFF, signed -> done after 4 edges, lt_o = 1.
- Handshake:
  - start_i held high during RUN with different operands -> ignored; the result matches the first request.
  - start_i high in the done cycle -> accepted, flags 0 at the next edge, second result correct.
- Reset mid-operation: rstn_i low at the 2nd RUN edge of the equal-operand case -> no done pulse, all outputs at reset values, ready_o = 1 next cycle.

Source files
------------

// File: rtl/cmp_iter.sv
// cmp_iter: iterative MSB-first magnitude comparator, CHUNK bits per cycle with early exit.
module cmp_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] TOP = IW'(NCH - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, done_q, done_d;
    logic [CHUNK-1:0] flip, ca, cb;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        done_d  = 1'b0;
        // Inverting the sign bit on the top chunk turns a signed compare into an unsigned one.
        flip = '0;
        flip[CHUNK-1] = sgn_q && (idx_q == TOP);
        ca = a_q[int'(idx_q)*CHUNK +: CHUNK] ^ flip;
        cb = b_q[int'(idx_q)*CHUNK +: CHUNK] ^ flip;
        if (state_q == IDLE) begin
            if (start_i) begin
                a_d     = a_i;
                b_d     = b_i;
                sgn_d   = signed_i;
                idx_d   = TOP;
                gt_d    = 1'b0;
                eq_d    = 1'b0;
                lt_d    = 1'b0;
                state_d = RUN;
            end
        end else if (ca != cb) begin
            gt_d    = ca > cb;
            lt_d    = ca < cb;
            done_d  = 1'b1;
            state_d = IDLE;
        end else if (idx_q == '0) begin
            eq_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
        end else begin
            idx_d = idx_q - IW'(1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            done_q  <= done_d;
        end
    end
    assign ready_o = state_q == IDLE;
    assign busy_o  = state_q == RUN;
    assign done_o  = done_q;
    assign gt_o    = gt_q;
    assign eq_o    = eq_q;
    assign lt_o    = lt_q;
endmodule

// File: tb/tb_cmp_iter.sv
// tb_cmp_iter: randomized and directed checks of cmp_iter against an arithmetic reference model.
module tb_cmp_iter;
    localparam int W = 32;
    localparam int C = 8;
    localparam int NCH = W / C;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready_o, busy_o, done_o, gt_o, eq_o, lt_o;
    int           n_chk = 0;
    int           n_fail = 0;

    cmp_iter #(.WIDTH(W), .CHUNK(C)) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .a_i(a), .b_i(b), .signed_i(sgn),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
        .gt_o(gt_o), .eq_o(eq_o), .lt_o(lt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {gt, eq, lt} from plain signed/unsigned arithmetic
    function automatic logic [2:0] exp_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        if (s) return {$signed(x) > $signed(y), x == y, $signed(x) < $signed(y)};
        return {x > y, x == y, x < y};
    endfunction

    // edges from accept to done: one plus the number of leading equal chunks, capped at NCH
    function automatic int exp_m(input logic [W-1:0] x, input logic [W-1:0] y);
        int m = 1;
        for (int i = NCH - 1; i > 0; i--) begin
            if (x[i*C +: C] != y[i*C +: C]) break;
            m++;
        end
        return m;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os, input bit hold);
        logic [2:0] r;
        int m;
        int cnt;
        r = exp_res(oa, ob, os);
        m = exp_m(oa, ob);
        cnt = 0;
        check("ready_pre", ready_o, 1);
        start = 1'b1;
        a = oa;
        b = ob;
        sgn = os;
        @(negedge clk);
        a = ~oa;
        b = ob ^ 32'h5a5a5a5a;
        sgn = ~os;
        if (!hold) start = 1'b0;
        check("flags_clr", {gt_o, eq_o, lt_o}, 0);
        check("ready_run", ready_o, 0);
        check("done_early", done_o, 0);
        while (!done_o && cnt < NCH + 2) begin
            check("busy_run", busy_o, 1);
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        check("latency", cnt, m);
        check("flags", {gt_o, eq_o, lt_o}, r);
        check("ready_done", ready_o, 1);
        check("busy_done", busy_o, 0);
    endtask

    task automatic idle_chk(input logic [2:0] r);
        @(negedge clk);
        check("done_pulse", done_o, 0);
        check("flags_hold", {gt_o, eq_o, lt_o}, r);
        check("ready_idle", ready_o, 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_flags", {gt_o, eq_o, lt_o}, 0);
        rstn = 1'b1;
        @(negedge clk);

        do_op(32'h12345678, 32'h12345678, 1'b0, 1'b0);
        idle_chk(3'b010);
        idle_chk(3'b010);
        do_op(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0);
        idle_chk(3'b100);
        do_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        idle_chk(3'b001);
        do_op(32'h00010000, 32'h0000FFFF, 1'b0, 1'b0);
        idle_chk(3'b100);
        do_op(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b1);
        idle_chk(3'b001);
        // back-to-back: second request issued in the done cycle of the first
        do_op(32'h0000_00FF, 32'h0000_0100, 1'b0, 1'b0);
        do_op(32'hFFFF_0000, 32'h0000_0001, 1'b1, 1'b0);
        idle_chk(3'b001);

        // abort in RUN: reset at the second RUN edge
        start = 1'b1;
        a = 32'h12345678;
        b = 32'h12345678;
        sgn = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_done", done_o, 0);
        check("abort_ready", ready_o, 1);
        check("abort_busy", busy_o, 0);
        check("abort_flags", {gt_o, eq_o, lt_o}, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("abort_done2", done_o, 0);
        check("abort_ready2", ready_o, 1);
        check("abort_busy2", busy_o, 0);

        for (int n = 0; n < 80; n++) begin
            ra = $urandom;
            rb = ra;
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 3) == 0) rb[i*C +: C] = C'($urandom);
            if ($urandom_range(0, 7) == 0) rb[W-1] = ~rb[W-1];
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_chk(exp_res(ra, rb, rs));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
